mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  Sequenced data-memory port downstream of MemoryControlSystem. Takes one request per
//  handshake: rw flag, 16-bit address-bus value, 32-bit store data. Runs it against an
//  internal single-port synchronous RAM with programmable wait states. Returns load data
//  to the LDR mux on a valid/ready response channel. One transaction in flight; no reordering.
// PARAMETERS
//  ADDR_W       16   request address width (matches address bus)
//  DATA_W       32   data word width
//  DEPTH        256  RAM words; addresses >= DEPTH are out of range
//  WAIT_CYCLES  2    extra stall cycles before the RAM access (0..15)
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       synchronous active-high reset
//  req_valid  in   1       request present
//  req_ready  out  1       unit can accept a request
//  req_rw     in   1       1 = store (write), 0 = load (read); same sense as MemoryControlSystem rw
//  req_addr   in   ADDR_W  word address
//  req_wdata  in   DATA_W  store data
//  rsp_valid  out  1       response present
//  rsp_ready  in   1       consumer takes response
//  rsp_rdata  out  DATA_W  load data; 0 for stores and errors
//  rsp_err    out  1       address out of range
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; busy=0;
//   wait counter=0. RAM contents are not cleared.
//  FSM: IDLE -> WAIT (WAIT_CYCLES>0) or ACCESS (WAIT_CYCLES=0) on req_valid&req_ready.
//   WAIT -> ACCESS when counter reaches WAIT_CYCLES-1. ACCESS -> RESP always.
//   RESP -> IDLE on rsp_ready.
//  Capture: rw/addr/wdata are registered on the accept edge. Later input changes are ignored.
//  req_ready=1 only in IDLE (combinational from state). No accept during RESP, even if
//   rsp_ready=1 in the same cycle; the next accept is possible one cycle after leaving RESP.
//  ACCESS: in-range store writes the RAM at the end of the cycle. In-range load reads the
//   RAM, and the data is registered into rsp_rdata on entry to RESP.
//  Out of range (addr >= DEPTH): no RAM write; rsp_rdata=0; rsp_err=1.
//  Latency: rsp_valid is first high WAIT_CYCLES+2 cycles after the accept edge.
//   rsp_* stay stable while rsp_valid=1 and rsp_ready=0.
//  On leaving RESP: rsp_valid=0; rsp_rdata and rsp_err are cleared to 0.
//  Address decode: only the low $clog2(DEPTH) bits index the RAM. The range check uses the
//   full ADDR_W bits, so there is no aliasing.
//  Reset in WAIT: the transaction is dropped and a pending store is never committed.
//   Reset in ACCESS wins over the write enable. Reset in RESP drops the response.
//  Wait counter: 4-bit, cleared on every accept, never wraps (exits at WAIT_CYCLES-1).
// STRUCTURE
//  Shared package mem_pkg: RW_READ=1'b0, RW_WRITE=1'b1; state encoding
//   typedef (IDLE, WAIT, ACCESS, RESP); opcode constants OP_MEM0=4'b1000,
//   OP_MEM1=4'b1001, OP_MEM2=4'b1010 shared with MemoryControlSystem.
//  Sub-module ram_sp: DEPTH x DATA_W single-port synchronous RAM with we, addr, wdata, and
//   registered rdata. Inferable; no reset.
//  Top level holds the FSM, the capture registers and the response registers.
// TESTING
//  1 Reset held 3 cycles -> req_ready=1, rsp_valid=0, rsp_rdata=0, busy=0.
//  2 Store rw=1, addr=0x0003, wdata=0x00000021; then load addr=0x0003 -> rsp_rdata=0x00000021,
//    rsp_err=0; rsp_valid rises exactly 4 cycles after each accept (WAIT_CYCLES=2).
//  3 Load addr=0x0100 (DEPTH=256) -> rsp_err=1, rsp_rdata=0. A store to 0x0100 does not
//    modify word 0x0000 (readback unchanged).
//  4 rsp_ready held low 5 cycles -> rsp_valid and rsp_rdata stable; req_ready=0; a
//    req_valid pulse in that window is not accepted.
//  5 Store to 0x0010 accepted, rst asserted in WAIT, then load 0x0010 -> old value
//    (preloaded 0x00000008) returned.
//  6 WAIT_CYCLES=0 build: back-to-back loads at 0x00FF and 0x0000 with rsp_ready=1 -> latency 2
//    cycles each; correct data; an accept occurs every 4 cycles.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants for the data-memory path: rw sense, state encoding and
// the memory opcodes that MemoryControlSystem also decodes.
package mem_pkg;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  localparam logic [3:0] OP_MEM0 = 4'b1000;
  localparam logic [3:0] OP_MEM1 = 4'b1001;
  localparam logic [3:0] OP_MEM2 = 4'b1010;

  // Full-width range check; the RAM index only uses the low bits, so this
  // is what keeps high addresses from aliasing onto real words.
  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response channel between the memory controller and the access unit.
interface mem_access_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_rw;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_rw, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_access_unit_ram_sp.sv
// Single-port synchronous RAM, registered read, no reset (infers block RAM).
module ram_sp #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 32,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write when enabled; read is registered every cycle (read-before-write).
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_access_unit.sv
// Sequenced data-memory port: one request in flight, optional wait states,
// then a single RAM access and a held response until the consumer takes it.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  mem_access_unit_if.slave    bus,
  output logic                busy
);

  localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_WAIT   = ST_WAIT;
  localparam logic [1:0] S_ACCESS = ST_ACCESS;
  localparam logic [1:0] S_RESP   = ST_RESP;

  logic [1:0]        state_reg, state_next;
  logic [3:0]        wait_cnt_reg;
  logic              access_phase_reg;
  logic              cap_rw_reg;
  logic [ADDR_W-1:0] cap_addr_reg;
  logic [DATA_W-1:0] cap_wdata_reg;
  logic [DATA_W-1:0] rsp_rdata_reg;
  logic              rsp_err_reg;

  logic              accept;
  logic              in_range;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;
  logic              access_done;

  assign accept        = bus.req_valid & bus.req_ready;
  assign in_range      = addr_in_range(32'(cap_addr_reg), DEPTH);
  // ACCESS spans two cycles: the first issues the RAM operation, the second
  // sees the RAM's registered read data so it can be latched into rsp_rdata.
  assign access_done   = (state_reg == S_ACCESS) & access_phase_reg;

  assign bus.req_ready = (state_reg == S_IDLE);
  assign bus.rsp_valid = (state_reg == S_RESP);
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign busy          = (state_reg != S_IDLE);

  // Reset is folded into the write enable so a reset in ACCESS always wins.
  assign ram_we = (state_reg == S_ACCESS) & ~access_phase_reg &
                  (cap_rw_reg == RW_WRITE) & in_range & ~rst;

  ram_sp #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (cap_addr_reg[IDX_W-1:0]),
    .wdata (cap_wdata_reg),
    .rdata (ram_rdata)
  );

  // Next-state decode for the IDLE/WAIT/ACCESS/RESP sequence.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          state_next = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        if (wait_cnt_reg == WAIT_LAST) begin
          state_next = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (access_phase_reg) begin
          state_next = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register and ACCESS sub-phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= S_IDLE;
      access_phase_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      access_phase_reg <= (state_reg == S_ACCESS) & ~access_phase_reg;
    end
  end

  // Request capture on accept and the saturating wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_reg  <= 4'd0;
      cap_rw_reg    <= RW_READ;
      cap_addr_reg  <= '0;
      cap_wdata_reg <= '0;
    end else if (accept) begin
      wait_cnt_reg  <= 4'd0;
      cap_rw_reg    <= bus.req_rw;
      cap_addr_reg  <= bus.req_addr;
      cap_wdata_reg <= bus.req_wdata;
    end else if ((state_reg == S_WAIT) && (wait_cnt_reg != WAIT_LAST)) begin
      wait_cnt_reg  <= wait_cnt_reg + 4'd1;
    end
  end

  // Response registers: loaded on entry to RESP, cleared when it is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else if (access_done) begin
      rsp_rdata_reg <= ((cap_rw_reg == RW_READ) && in_range) ? ram_rdata : '0;
      rsp_err_reg   <= ~in_range;
    end else if ((state_reg == S_RESP) && bus.rsp_ready) begin
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end
  end

endmodule
